// File: rtl/segrw_pkg.sv
// Shared definitions for the two-requester segment read/write arbiter.
//   SEGRW_AW / SEGRW_DW : default address / data widths
//   req_id_t            : requester identifier (REQ_0 / REQ_1)
//   OP_READ / OP_WRITE  : encoding of the req_write / seg_write flag
//   other_req()         : the requester that is not the given one
package segrw_pkg;

  localparam int unsigned SEGRW_AW = 4;
  localparam int unsigned SEGRW_DW = 8;

  typedef enum logic {
    REQ_0 = 1'b0,
    REQ_1 = 1'b1
  } req_id_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_0) ? REQ_1 : REQ_0;
  endfunction

endpackage

// File: rtl/segrw_resp_buf.sv
// One-entry read-response holding register.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load         : capture load_data and mark the entry valid
//   load_data    : data to capture
//   ready        : consumer takes the entry when valid && ready
//   valid, data  : entry state presented to the consumer
module segrw_resp_buf
  import segrw_pkg::*;
#(
  parameter int unsigned DW = SEGRW_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/segrw_arb2.sv
// Two-requester round-robin arbiter and sequencer for one segment
// read/write port. One command is granted per cycle; the single
// outstanding read is tracked and its data steered into the issuing
// requester's one-entry response buffer.
//   clock, reset                 : rising-edge clock, sync active-high reset
//   req_valid/addr/dataW/write_k : command stream from requester k
//   req_ready_k                  : command k accepted this cycle (comb)
//   resp_valid_k, resp_dataR_k   : buffered read data for requester k
//   resp_ready_k                 : requester k consumes its response
//   seg_valid/addr/dataW/write   : command issued to the segment (comb)
//   seg_ready                    : segment accepts the issued command
//   seg_dataR, seg_rvalid        : read return, one cycle after a read grant
//   err                          : sticky unsolicited-read-data error
module segrw_arb2
  import segrw_pkg::*;
#(
  parameter int unsigned AW = SEGRW_AW,
  parameter int unsigned DW = SEGRW_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid_0,
  input  logic [AW-1:0] req_addr_0,
  input  logic [DW-1:0] req_dataW_0,
  input  logic          req_write_0,
  output logic          req_ready_0,
  input  logic          req_valid_1,
  input  logic [AW-1:0] req_addr_1,
  input  logic [DW-1:0] req_dataW_1,
  input  logic          req_write_1,
  output logic          req_ready_1,
  output logic          resp_valid_0,
  output logic [DW-1:0] resp_dataR_0,
  input  logic          resp_ready_0,
  output logic          resp_valid_1,
  output logic [DW-1:0] resp_dataR_1,
  input  logic          resp_ready_1,
  output logic          seg_valid,
  input  logic          seg_ready,
  output logic [AW-1:0] seg_addr,
  output logic [DW-1:0] seg_dataW,
  output logic          seg_write,
  input  logic [DW-1:0] seg_dataR,
  input  logic          seg_rvalid,
  output logic          err
);

  req_id_t last_grant;
  req_id_t pend_id;
  req_id_t winner;
  logic    pend_valid;
  logic    rst_seen;
  logic    elig_0;
  logic    elig_1;
  logic    grant;
  logic    load_0;
  logic    load_1;

  // A read may only issue when its buffer is empty and no read of the
  // same requester is in flight; writes are never held back by that.
  assign elig_0 = req_valid_0 &&
                  ((req_write_0 == OP_WRITE) ||
                   (!resp_valid_0 && !(pend_valid && (pend_id == REQ_0))));
  assign elig_1 = req_valid_1 &&
                  ((req_write_1 == OP_WRITE) ||
                   (!resp_valid_1 && !(pend_valid && (pend_id == REQ_1))));

  always_comb begin
    winner = REQ_0;
    if (elig_0 && elig_1) begin
      winner = other_req(last_grant);
    end else if (elig_1) begin
      winner = REQ_1;
    end
  end

  // Outputs are gated by reset so the segment sees nothing while in reset.
  always_comb begin
    seg_valid = 1'b0;
    seg_addr  = '0;
    seg_dataW = '0;
    seg_write = 1'b0;
    if (!reset && (elig_0 || elig_1)) begin
      seg_valid = 1'b1;
      if (winner == REQ_0) begin
        seg_addr  = req_addr_0;
        seg_dataW = req_dataW_0;
        seg_write = req_write_0;
      end else begin
        seg_addr  = req_addr_1;
        seg_dataW = req_dataW_1;
        seg_write = req_write_1;
      end
    end
  end

  assign grant       = seg_valid && seg_ready;
  assign req_ready_0 = grant && (winner == REQ_0);
  assign req_ready_1 = grant && (winner == REQ_1);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= REQ_1;
      pend_valid <= 1'b0;
      pend_id    <= REQ_0;
      err        <= 1'b0;
      rst_seen   <= 1'b1;
    end else begin
      rst_seen   <= 1'b0;
      pend_valid <= grant && (seg_write == OP_READ);
      if (grant) begin
        last_grant <= winner;
        pend_id    <= winner;
      end
      // Read data left over from before reset is tolerated in the first cycle.
      if (seg_rvalid && !pend_valid && !rst_seen) begin
        err <= 1'b1;
      end
    end
  end

  assign load_0 = !reset && seg_rvalid && pend_valid && (pend_id == REQ_0);
  assign load_1 = !reset && seg_rvalid && pend_valid && (pend_id == REQ_1);

  segrw_resp_buf #(.DW(DW)) u_resp_0 (
    .clock     (clock),
    .reset     (reset),
    .load      (load_0),
    .load_data (seg_dataR),
    .ready     (resp_ready_0),
    .valid     (resp_valid_0),
    .data      (resp_dataR_0)
  );

  segrw_resp_buf #(.DW(DW)) u_resp_1 (
    .clock     (clock),
    .reset     (reset),
    .load      (load_1),
    .load_data (seg_dataR),
    .ready     (resp_ready_1),
    .valid     (resp_valid_1),
    .data      (resp_dataR_1)
  );

endmodule
